// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with a per-register busy scoreboard
//
// Two combinational read ports (A, B), two write ports (0, 1; port 1 wins on an
// address collision) and one issue port that marks a destination register as
// having a pending write. An effective write to a register clears its busy bit;
// an issue to the same register in the same cycle keeps it busy.
//
// Parameters:
//   WIDTH    data width in bits
//   DEPTH    number of registers (power of 2, >= 2); AW = log2(DEPTH)
//   ZERO_REG 1 = register 0 reads as zero, ignores writes and is never busy
//
// Ports:
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   RA, RB                read addresses
//   BusA, BusB            read data
//   BusyA, BusyB          busy bit of RA, RB
//   RegWr0/1, RW0/1       write enables and write addresses
//   BusW0/1               write data
//   IssueEn, IssueRd      mark IssueRd busy at the next rising edge
//
// Build option:
//   REGFILE_BYPASS_EN     when defined, reads forward same-cycle write data
//                         (port 1 over port 0) and the matching busy output
//                         reads 0 unless the same register is being issued.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  DEPTH    = 32,
    parameter int unsigned  ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic             BusyA,
    output logic             BusyB,
    input  logic             RegWr0,
    input  logic             RegWr1,
    input  logic [AW-1:0]    RW0,
    input  logic [AW-1:0]    RW1,
    input  logic [WIDTH-1:0] BusW0,
    input  logic [WIDTH-1:0] BusW1,
    input  logic             IssueEn,
    input  logic [AW-1:0]    IssueRd
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [WIDTH-1:0] gpr_q [DEPTH];
    logic [WIDTH-1:0] gpr_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr0_eff;
    logic wr1_eff;
    logic iss_eff;

    // Effective operations: gated by reset so nothing (including forwarding)
    // is visible while Rst_n is low, and dropped for a hardwired register 0.
    always_comb begin
        wr0_eff = Rst_n && RegWr0  && !(ZERO_EN && (RW0 == '0));
        wr1_eff = Rst_n && RegWr1  && !(ZERO_EN && (RW1 == '0));
        iss_eff = Rst_n && IssueEn && !(ZERO_EN && (IssueRd == '0));
    end

    // Next state: port 1 is applied after port 0 so it wins a collision;
    // issue is applied after the write clears so it wins over a same-cycle write.
    always_comb begin
        gpr_d  = gpr_q;
        busy_d = busy_q;
        if (wr0_eff) begin
            gpr_d[RW0]  = BusW0;
            busy_d[RW0] = 1'b0;
        end
        if (wr1_eff) begin
            gpr_d[RW1]  = BusW1;
            busy_d[RW1] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[IssueRd] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            gpr_q  <= gpr_d;
            busy_q <= busy_d;
        end
    end

    // Read port A
    always_comb begin
        BusA  = gpr_q[RA];
        BusyA = busy_q[RA];
`ifdef REGFILE_BYPASS_EN
        if (wr1_eff && (RW1 == RA)) begin
            BusA  = BusW1;
            BusyA = iss_eff && (IssueRd == RA);
        end else if (wr0_eff && (RW0 == RA)) begin
            BusA  = BusW0;
            BusyA = iss_eff && (IssueRd == RA);
        end
`endif
        if (ZERO_EN && (RA == '0)) begin
            BusA  = '0;
            BusyA = 1'b0;
        end
    end

    // Read port B
    always_comb begin
        BusB  = gpr_q[RB];
        BusyB = busy_q[RB];
`ifdef REGFILE_BYPASS_EN
        if (wr1_eff && (RW1 == RB)) begin
            BusB  = BusW1;
            BusyB = iss_eff && (IssueRd == RB);
        end else if (wr0_eff && (RW0 == RB)) begin
            BusB  = BusW0;
            BusyB = iss_eff && (IssueRd == RB);
        end
`endif
        if (ZERO_EN && (RB == '0)) begin
            BusB  = '0;
            BusyB = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- scoreboard bench for regfile_mp.
// Two instances: default (32x32, zero register) and small (16-bit x 8, no zero
// register). The driver pushes the expected read-port values from a reference
// model into a queue; the monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    typedef struct packed {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw0;
        logic [4:0]  rw1;
        logic [4:0]  ird;
        logic        we0;
        logic        we1;
        logic        ien;
        logic [31:0] w0;
        logic [31:0] w1;
    } stim_t;

    typedef struct {
        string       name;
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
    } exp_t;

    logic  clk;
    logic  rst_n;
    stim_t s_big;
    stim_t s_sm;

    logic [31:0] bus_a_big, bus_b_big;
    logic        busy_a_big, busy_b_big;
    logic [15:0] bus_a_sm, bus_b_sm;
    logic        busy_a_sm, busy_b_sm;

    int checks;
    int failures;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: register contents and busy flags per instance
    logic [31:0] mem  [2][32];
    logic        busy [2][32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_mp u_big (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .RA      (s_big.ra),
        .RB      (s_big.rb),
        .BusA    (bus_a_big),
        .BusB    (bus_b_big),
        .BusyA   (busy_a_big),
        .BusyB   (busy_b_big),
        .RegWr0  (s_big.we0),
        .RegWr1  (s_big.we1),
        .RW0     (s_big.rw0),
        .RW1     (s_big.rw1),
        .BusW0   (s_big.w0),
        .BusW1   (s_big.w1),
        .IssueEn (s_big.ien),
        .IssueRd (s_big.ird)
    );

    regfile_mp #(
        .WIDTH    (16),
        .DEPTH    (8),
        .ZERO_REG (0)
    ) u_sm (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .RA      (s_sm.ra[2:0]),
        .RB      (s_sm.rb[2:0]),
        .BusA    (bus_a_sm),
        .BusB    (bus_b_sm),
        .BusyA   (busy_a_sm),
        .BusyB   (busy_b_sm),
        .RegWr0  (s_sm.we0),
        .RegWr1  (s_sm.we1),
        .RW0     (s_sm.rw0[2:0]),
        .RW1     (s_sm.rw1[2:0]),
        .BusW0   (s_sm.w0[15:0]),
        .BusW1   (s_sm.w1[15:0]),
        .IssueEn (s_sm.ien),
        .IssueRd (s_sm.ird[2:0])
    );

    function automatic bit is_zero(int d, logic [4:0] a);
        return (d == 0) && (a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(int d, stim_t s, logic rst, logic [4:0] a);
        if (is_zero(d, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rst && s.we1 && s.rw1 == a) return s.w1;
        if (rst && s.we0 && s.rw0 == a) return s.w0;
`endif
        return mem[d][a];
    endfunction

    function automatic logic exp_busy(int d, stim_t s, logic rst, logic [4:0] a);
        if (is_zero(d, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rst && ((s.we1 && s.rw1 == a) || (s.we0 && s.rw0 == a)))
            return s.ien && s.ird == a;
`endif
        return busy[d][a];
    endfunction

    // State after a rising edge with reset released
    task automatic model_update(int d, stim_t s);
        if (s.we0 && !is_zero(d, s.rw0)) begin
            mem[d][s.rw0]  = s.w0;
            busy[d][s.rw0] = 1'b0;
        end
        if (s.we1 && !is_zero(d, s.rw1)) begin
            mem[d][s.rw1]  = s.w1;
            busy[d][s.rw1] = 1'b0;
        end
        if (s.ien && !is_zero(d, s.ird)) busy[d][s.ird] = 1'b1;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                mem[d][i]  = 32'h0;
                busy[d][i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int d, input stim_t s_in, input logic rst, input string name);
        stim_t s;
        exp_t  e;
        s = s_in;
        if (d == 1) begin
            s.ra  = s.ra  & 5'd7;
            s.rb  = s.rb  & 5'd7;
            s.rw0 = s.rw0 & 5'd7;
            s.rw1 = s.rw1 & 5'd7;
            s.ird = s.ird & 5'd7;
            s.w0  = s.w0  & 32'hFFFF;
            s.w1  = s.w1  & 32'hFFFF;
        end
        @(posedge clk);
        #1;
        rst_n = rst;
        if (d == 0) begin
            s_big = s;
            s_sm  = '0;
        end else begin
            s_sm  = s;
            s_big = '0;
        end
        if (!rst) model_clear();
        e.name = name;
        e.d    = d;
        e.a    = exp_data(d, s, rst, s.ra);
        e.b    = exp_data(d, s, rst, s.rb);
        e.ba   = exp_busy(d, s, rst, s.ra);
        e.bb   = exp_busy(d, s, rst, s.rb);
        exp_q.push_back(e);
        // Inputs are held through the next rising edge
        if (rst) model_update(d, s);
    endtask

    task automatic op(input int d, input logic rst, input string name,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic we0, input logic [4:0] rw0, input logic [31:0] w0,
                      input logic we1, input logic [4:0] rw1, input logic [31:0] w1,
                      input logic ien, input logic [4:0] ird);
        stim_t s;
        s.ra  = ra;
        s.rb  = rb;
        s.we0 = we0;
        s.rw0 = rw0;
        s.w0  = w0;
        s.we1 = we1;
        s.rw1 = rw1;
        s.w1  = w1;
        s.ien = ien;
        s.ird = ird;
        run(d, s, rst, name);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic random_cycles(input int d, input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s.ra  = rnd_addr();
            s.rb  = rnd_addr();
            s.rw0 = rnd_addr();
            s.rw1 = rnd_addr();
            s.ird = rnd_addr();
            s.we0 = ($urandom_range(0, 1) == 1);
            s.we1 = ($urandom_range(0, 2) == 0);
            s.ien = ($urandom_range(0, 2) == 0);
            s.w0  = $urandom();
            s.w1  = $urandom();
            run(d, s, ($urandom_range(0, 59) != 0), "random");
        end
    endtask

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s %s: got %h expected %h", name, what, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.d == 0) begin
                check(mon_e.name, "BusA",  bus_a_big, mon_e.a);
                check(mon_e.name, "BusB",  bus_b_big, mon_e.b);
                check(mon_e.name, "BusyA", {31'h0, busy_a_big}, {31'h0, mon_e.ba});
                check(mon_e.name, "BusyB", {31'h0, busy_b_big}, {31'h0, mon_e.bb});
            end else begin
                check(mon_e.name, "BusA",  {16'h0, bus_a_sm}, mon_e.a);
                check(mon_e.name, "BusB",  {16'h0, bus_b_sm}, mon_e.b);
                check(mon_e.name, "BusyA", {31'h0, busy_a_sm}, {31'h0, mon_e.ba});
                check(mon_e.name, "BusyB", {31'h0, busy_b_sm}, {31'h0, mon_e.bb});
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        s_big    = '0;
        s_sm     = '0;
        model_clear();

        //      d rst name           ra  rb  we0 rw0 w0            we1 rw1 w1            ien ird
        op(0, 0, "reset_idle",   5,  5,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "wr_r5",        5,  5,  1,  5, 32'hDEADBEEF, 0,  0, 32'h0,        1,  5);
        op(0, 1, "rd_r5",        5,  5,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 0, "rst_async",    5,  5,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 0, "rst_ignore",   5,  6,  1,  5, 32'h1234,     1,  6, 32'h5678,     1,  6);
        op(0, 1, "rst_release",  5,  6,  1,  6, 32'hCAFEF00D, 0,  0, 32'h0,        1,  5);
        op(0, 1, "first_wr",     5,  6,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "zr_wr",        0,  0,  1,  0, 32'h12345678, 0,  0, 32'h0,        1,  0);
        op(0, 1, "zr_rd",        0,  0,  0,  0, 32'h0,        0,  0, 32'h0,        1,  0);
        op(0, 1, "coll_wr",      7,  7,  1,  7, 32'h11111111, 1,  7, 32'h22222222, 0,  0);
        op(0, 1, "coll_rd",      7,  7,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "sb_issue",     9,  9,  0,  0, 32'h0,        0,  0, 32'h0,        1,  9);
        op(0, 1, "sb_busy2",     9,  9,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "sb_busy3",     0,  9,  0,  0, 32'h0,        0,  0, 32'h0,        1, 10);
        op(0, 1, "sb_write4",   10,  9,  0,  0, 32'h0,        1,  9, 32'h99,       0,  0);
        op(0, 1, "sb_clear5",   10,  9,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "sb_iss_wr",    9,  9,  1,  9, 32'h999,      0,  0, 32'h0,        1,  9);
        op(0, 1, "sb_kept",      9,  9,  0,  0, 32'h0,        0,  0, 32'h0,        1,  9);
        op(0, 1, "sb_rebusy",    9, 10,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(0, 1, "byp_init",     3,  3,  1,  3, 32'hA,        0,  0, 32'h0,        0,  0);
        op(0, 1, "byp_same",     3,  0,  1,  3, 32'hB,        0,  0, 32'h0,        0,  0);
        op(0, 1, "byp_after",    3,  3,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(1, 1, "sm_wr",        0,  7,  1,  0, 32'hFFFF,     1,  7, 32'hFFFF,     1,  0);
        op(1, 1, "sm_rd",        0,  7,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);
        op(1, 1, "sm_clr",       0,  7,  1,  0, 32'h1234,     0,  0, 32'h0,        0,  0);
        op(1, 1, "sm_rd2",       0,  7,  0,  0, 32'h0,        0,  0, 32'h0,        0,  0);

        random_cycles(0, 400);
        random_cycles(1, 150);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, register count (power of 2, >=2); AW = log2(DEPTH) SHALL be derived internally.
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports RA, RB  input  AW  read addresses A, B.
REQ-007 SHALL have ports BusA, BusB  output  WIDTH  read data A, B.
REQ-008 SHALL have ports BusyA, BusyB  output  1  scoreboard busy bit of RA, RB.
REQ-009 SHALL have ports RegWr0, RegWr1  input  1  write enables, ports 0 and 1.
REQ-010 SHALL have ports RW0, RW1  input  AW  write addresses.
REQ-011 SHALL have ports BusW0, BusW1  input  WIDTH  write data.
REQ-012 SHALL have port IssueEn  input  1  marks IssueRd as pending-write (busy).
REQ-013 SHALL have port IssueRd  input  AW  destination register being issued.

Function
REQ-014 Reads SHALL be combinational: BusA = GPR[RA], BusB = GPR[RB]; zero latency.
REQ-015 With ZERO_REG=1, reads of address 0 SHALL return 0 and BusyA/BusyB SHALL be 0 for address 0.
REQ-016 Write port n SHALL update GPR[RWn] at rising Clk when RegWrn=1; writes to address 0 SHALL be dropped when ZERO_REG=1.
REQ-017 Simultaneous writes to the same address SHALL store BusW1 (port 1 priority).
REQ-018 Busy bit of IssueRd SHALL set at rising Clk when IssueEn=1 (except address 0 with ZERO_REG=1).
REQ-019 Busy bit of an address SHALL clear at rising Clk when an effective write to it occurs on either port.
REQ-020 Issue and write to the same address in the same cycle SHALL leave busy set (issue wins).
REQ-021 Busy bits of unrelated addresses SHALL be unaffected; re-issue of an already-busy address SHALL keep it busy.
REQ-022 BusyA/BusyB SHALL be combinational reads of the busy vector at RA/RB.

Reset
REQ-023 Rst_n=0 SHALL immediately, without Clk, clear all GPR entries to 0 and all busy bits to 0.
REQ-024 While Rst_n=0, writes and issues SHALL be ignored; BusA, BusB SHALL read 0 and BusyA, BusyB SHALL be 0.
REQ-025 Deassertion SHALL take effect synchronously; the first write/issue SHALL be accepted on the first rising Clk with Rst_n=1.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: a read whose address matches an effective same-cycle write SHALL return that write data (BusW1 over BusW0), and the matching Busy output SHALL read 0 unless IssueEn targets the same address.
REQ-027 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the stored value; written data SHALL be visible only after the rising edge; no forwarding logic SHALL be present.

Verification
REQ-028 Reset: write 0xDEADBEEF to R5, pulse Rst_n low mid-cycle -> BusA with RA=5 reads 0x00000000 immediately, BusyA=0.
REQ-029 Zero reg: RegWr0=1, RW0=0, BusW0=0x12345678 -> next cycle RA=0 reads 0; IssueEn with IssueRd=0 -> BusyA=0.
REQ-030 Dual write collision: RW0=RW1=7, BusW0=0x11111111, BusW1=0x22222222 -> after edge R7 reads 0x22222222.
REQ-031 Scoreboard: issue R9 cycle 1 -> BusyB=1 (RB=9) from cycle 2; write R9 cycle 4 -> BusyB=0 from cycle 5; issue+write R9 same cycle -> BusyB stays 1.
REQ-032 Bypass: R3=0xA, same-cycle write 0xB on port 0 with RA=3 -> BusA=0xB before edge with REGFILE_BYPASS_EN, 0xA without; 0xB after edge in both builds.
REQ-033 Parameters: WIDTH=16, DEPTH=8, ZERO_REG=0 -> write 0xFFFF to R0 and R7 read back 0xFFFF; R0 busy tracking operates.
